mips_harvard_cpu: RTL and testbench

Single-cycle, 32-bit MIPS I subset CPU core with separate instruction and data buses (Harvard organisation). It fetches one instruction per enabled clock from an external combinational instruction ROM and executes it, honouring MIPS branch-delay slots. It accesses an external data memory (`mips_cpu_data_memory`, not part of this block) and exposes `$v0` for observation. It halts by jumping to address 0.

---
 rtl/mips_cpu_pkg.sv | 50 +++++
 rtl/mips_cpu_if.sv | 20 ++
 rtl/mips_cpu_regfile.sv | 30 +++
 rtl/mips_harvard_cpu.sv | 152 +++++++++++++++
 tb/tb_mips_harvard_cpu.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the Harvard MIPS core: opcode/funct encodings, fixed addresses,
// and the bus byte-lane swap.
package mips_cpu_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR    = 32'h00000000;

  typedef enum logic [5:0] {
    OpSpecial = 6'h00,
    OpJ       = 6'h02,
    OpJal     = 6'h03,
    OpBeq     = 6'h04,
    OpBne     = 6'h05,
    OpBlez    = 6'h06,
    OpBgtz    = 6'h07,
    OpAddiu   = 6'h09,
    OpSlti    = 6'h0A,
    OpSltiu   = 6'h0B,
    OpAndi    = 6'h0C,
    OpOri     = 6'h0D,
    OpXori    = 6'h0E,
    OpLui     = 6'h0F,
    OpLw      = 6'h23,
    OpSw      = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FnSll  = 6'h00,
    FnSrl  = 6'h02,
    FnSra  = 6'h03,
    FnSllv = 6'h04,
    FnSrlv = 6'h06,
    FnSrav = 6'h07,
    FnJr   = 6'h08,
    FnJalr = 6'h09,
    FnAddu = 6'h21,
    FnSubu = 6'h23,
    FnAnd  = 6'h24,
    FnOr   = 6'h25,
    FnXor  = 6'h26,
    FnNor  = 6'h27,
    FnSlt  = 6'h2A,
    FnSltu = 6'h2B
  } funct_e;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_cpu_if.sv
// Instruction and data bus bundle; the core is the master, memories are the slave.
interface mips_cpu_if;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  modport master (
    output instr_address, data_address, data_write, data_read, data_writedata,
    input  instr_readdata, data_readdata
  );

  modport slave (
    input  instr_address, data_address, data_write, data_read, data_writedata,
    output instr_readdata, data_readdata
  );
endinterface

// File: rtl/mips_cpu_regfile.sv
// 32x32 GPR file: two asynchronous read ports, one synchronous write port, $2 tap.
module mips_cpu_regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] v0_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // $0 is never written and resets to zero, so it always reads zero.
  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];
  assign v0_o      = regs_q[2];

endmodule

// File: rtl/mips_harvard_cpu.sv
// Single-cycle MIPS I subset core with delay slots; halts on reaching address 0.
// Define MIPS_CPU_UNKNOWN_HALT_EN to halt on unsupported encodings instead of NOP.
module mips_harvard_cpu
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        active,
  output logic [31:0] register_v0,
  mips_cpu_if.master  bus
);

  logic [31:0] pc_q, pc_d, npc_q, npc_d;
  logic        active_q, active_d;

  logic [31:0] instr, rs_data, rt_data, simm, zimm, pc_plus4, target, wb_data;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, wb_addr;
  logic [15:0] imm;
  logic [25:0] idx;
  logic        wb_en, taken, is_lw, is_sw, known, retire, exec;

  assign instr    = bswap(bus.instr_readdata);
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign idx      = instr[25:0];
  assign simm     = {{16{imm[15]}}, imm};
  assign zimm     = {16'h0000, imm};
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    wb_en   = 1'b0;
    wb_addr = rt;
    wb_data = '0;
    taken   = 1'b0;
    target  = pc_plus4 + (simm << 2);
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    known   = 1'b1;
    case (op)
      OpSpecial: begin
        wb_en   = 1'b1;
        wb_addr = rd;
        case (funct)
          FnSll:  wb_data = rt_data << shamt;
          FnSrl:  wb_data = rt_data >> shamt;
          FnSra:  wb_data = $signed(rt_data) >>> shamt;
          FnSllv: wb_data = rt_data << rs_data[4:0];
          FnSrlv: wb_data = rt_data >> rs_data[4:0];
          FnSrav: wb_data = $signed(rt_data) >>> rs_data[4:0];
          FnJr:   begin wb_en = 1'b0; taken = 1'b1; target = rs_data; end
          FnJalr: begin taken = 1'b1; target = rs_data; wb_data = pc_q + 32'd8; end
          FnAddu: wb_data = rs_data + rt_data;
          FnSubu: wb_data = rs_data - rt_data;
          FnAnd:  wb_data = rs_data & rt_data;
          FnOr:   wb_data = rs_data | rt_data;
          FnXor:  wb_data = rs_data ^ rt_data;
          FnNor:  wb_data = ~(rs_data | rt_data);
          FnSlt:  wb_data = {31'd0, $signed(rs_data) < $signed(rt_data)};
          FnSltu: wb_data = {31'd0, rs_data < rt_data};
          default: begin wb_en = 1'b0; known = 1'b0; end
        endcase
      end
      OpJ:     begin taken = 1'b1; target = {pc_plus4[31:28], idx, 2'b00}; end
      OpJal: begin
        taken   = 1'b1;
        target  = {pc_plus4[31:28], idx, 2'b00};
        wb_en   = 1'b1;
        wb_addr = 5'd31;
        wb_data = pc_q + 32'd8;
      end
      OpBeq:   taken = (rs_data == rt_data);
      OpBne:   taken = (rs_data != rt_data);
      OpBlez:  taken = rs_data[31] || (rs_data == '0);
      OpBgtz:  taken = !rs_data[31] && (rs_data != '0);
      OpAddiu: begin wb_en = 1'b1; wb_data = rs_data + simm; end
      OpSlti:  begin wb_en = 1'b1; wb_data = {31'd0, $signed(rs_data) < $signed(simm)}; end
      OpSltiu: begin wb_en = 1'b1; wb_data = {31'd0, rs_data < simm}; end
      OpAndi:  begin wb_en = 1'b1; wb_data = rs_data & zimm; end
      OpOri:   begin wb_en = 1'b1; wb_data = rs_data | zimm; end
      OpXori:  begin wb_en = 1'b1; wb_data = rs_data ^ zimm; end
      OpLui:   begin wb_en = 1'b1; wb_data = {imm, 16'h0000}; end
      OpLw:    begin is_lw = 1'b1; wb_en = 1'b1; wb_data = bswap(bus.data_readdata); end
      OpSw:    is_sw = 1'b1;
      default: known = 1'b0;
    endcase
  end

`ifdef MIPS_CPU_UNKNOWN_HALT_EN
  assign retire = known;
`else
  logic unused_known;
  assign unused_known = known;
  assign retire       = 1'b1;
`endif

  assign exec = clk_enable && active_q;

  always_comb begin
    pc_d     = pc_q;
    npc_d    = npc_q;
    active_d = active_q;
    if (exec) begin
      if (!retire) begin
        active_d = 1'b0;
      end else begin
        pc_d  = npc_q;
        npc_d = taken ? target : npc_q + 32'd4;
        if (npc_q == HALT_ADDR) active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_VECTOR;
      npc_q    <= RESET_VECTOR + 32'd4;
      active_q <= 1'b1;
    end else begin
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      active_q <= active_d;
    end
  end

  mips_cpu_regfile u_regfile (
    .clk_i     (clk),
    .rst_ni    (reset),
    .raddr_a_i (rs),
    .rdata_a_o (rs_data),
    .raddr_b_i (rt),
    .rdata_b_o (rt_data),
    .we_i      (exec && retire && wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .v0_o      (register_v0)
  );

  assign active             = active_q;
  assign bus.instr_address  = pc_q;
  assign bus.data_address   = rs_data + simm;
  assign bus.data_writedata = bswap(rt_data);
  assign bus.data_write     = exec && is_sw;
  assign bus.data_read      = active_q && is_lw;

endmodule

// File: tb/tb_mips_harvard_cpu.sv
// Directed-program bench for mips_harvard_cpu with a little-endian ROM and data RAM model.
module tb_mips_harvard_cpu;

  logic        clk, reset, clk_enable, active;
  logic [31:0] register_v0;
  logic [31:0] rom  [32];
  logic [31:0] dmem [16];
  logic [31:0] rom_off;
  int          n_checks, n_fail;
  int          edges, writes;

  mips_cpu_if bus ();

  mips_harvard_cpu dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .active      (active),
    .register_v0 (register_v0),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_off            = bus.instr_address - 32'hBFC00000;
  assign bus.instr_readdata = (rom_off < 32'd128) ? rom[rom_off[6:2]] : 32'h0;
  assign bus.data_readdata  = dmem[bus.data_address[5:2]];

  always @(posedge clk) if (bus.data_write) dmem[bus.data_address[5:2]] <= bus.data_writedata;

  function automatic logic [31:0] bsw(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) rom[i] = 32'h0;
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
  endtask

  task automatic put(input int i, input logic [31:0] instr);
    rom[i] = bsw(instr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b0;
    clk_enable = 1'b1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_halt(input int budget, output int n_edges, output int n_writes);
    n_edges  = 0;
    n_writes = 0;
    while (active && n_edges < budget) begin
      if (bus.data_write) n_writes++;
      step();
      n_edges++;
    end
    if (active) check("halt_timeout", {31'd0, active}, 32'd0);
  endtask

  localparam logic [31:0] JR0  = 32'h00000008;
  localparam logic [31:0] NOP  = 32'h00000000;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    clk_enable = 1'b1;

    // Halt on JR $0 with v0 untouched
    clear_prog();
    put(0, enc_i(6'h09, 5'd2, 5'd2, 16'h0000));
    put(1, enc_i(6'h09, 5'd2, 5'd2, 16'h0000));
    put(2, JR0);
    put(3, enc_i(6'h09, 5'd0, 5'd0, 16'h0000));
    do_reset();
    check("rst_pc", bus.instr_address, 32'hBFC00000);
    check("rst_active", {31'd0, active}, 32'd1);
    check("rst_strobes", {30'd0, bus.data_read, bus.data_write}, 32'd0);
    check("rst_v0", register_v0, 32'd0);
    run_halt(20, edges, writes);
    check("p1_edges", edges, 32'd4);
    check("p1_pc", bus.instr_address, 32'h0);
    check("p1_v0", register_v0, 32'd0);
    step();
    step();
    check("p1_halt_pc", bus.instr_address, 32'h0);
    check("p1_halt_active", {31'd0, active}, 32'd0);

    // Countdown, then asynchronous reset out of halt
    clear_prog();
    put(0, enc_i(6'h09, 5'd0, 5'd2, 16'h0005));
    put(1, enc_i(6'h09, 5'd2, 5'd2, 16'hFFFF));
    put(2, JR0);
    put(3, NOP);
    do_reset();
    run_halt(20, edges, writes);
    check("p2_edges", edges, 32'd4);
    check("p2_v0", register_v0, 32'd4);
    #2 reset = 1'b0;
    #1;
    check("async_rst_active", {31'd0, active}, 32'd1);
    check("async_rst_pc", bus.instr_address, 32'hBFC00000);
    check("async_rst_v0", register_v0, 32'd0);

    // Store / load round trip with byte-swapped bus
    clear_prog();
    put(0, enc_i(6'h0F, 5'd0, 5'd3, 16'h1234));
    put(1, enc_i(6'h0D, 5'd3, 5'd3, 16'h5678));
    put(2, enc_i(6'h2B, 5'd0, 5'd3, 16'h0000));
    put(3, enc_i(6'h23, 5'd0, 5'd2, 16'h0000));
    put(4, JR0);
    put(5, NOP);
    do_reset();
    step();
    step();
    check("sw_strobe", {31'd0, bus.data_write}, 32'd1);
    check("sw_addr", bus.data_address, 32'h0);
    check("sw_wdata", bus.data_writedata, 32'h78563412);
    run_halt(20, edges, writes);
    check("p3_edges", edges, 32'd4);
    check("p3_writes", writes, 32'd1);
    check("p3_mem", dmem[0], 32'h78563412);
    check("p3_v0", register_v0, 32'h12345678);

    // Taken branch: delay slot runs, skipped instruction does not
    clear_prog();
    put(0, enc_i(6'h04, 5'd0, 5'd0, 16'h0002));
    put(1, enc_i(6'h09, 5'd0, 5'd2, 16'h0001));
    put(2, enc_i(6'h09, 5'd2, 5'd2, 16'h0001));
    put(3, JR0);
    put(4, NOP);
    do_reset();
    run_halt(20, edges, writes);
    check("p4_edges", edges, 32'd4);
    check("p4_v0", register_v0, 32'd1);

    // Clock-enable hold mid-program
    clear_prog();
    put(0, enc_i(6'h09, 5'd0, 5'd2, 16'h0005));
    put(1, enc_i(6'h09, 5'd2, 5'd2, 16'hFFFF));
    put(2, JR0);
    put(3, NOP);
    do_reset();
    step();
    step();
    clk_enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("hold_pc", bus.instr_address, 32'hBFC00008);
    check("hold_v0", register_v0, 32'd4);
    check("hold_active", {31'd0, active}, 32'd1);
    clk_enable = 1'b1;
    run_halt(20, edges, writes);
    check("p5_edges", edges, 32'd2);
    check("p5_v0", register_v0, 32'd4);

    // ALU ops, result checked in v0 after each edge ($4 = -8)
    begin
      logic [31:0] exp_v0 [11];
      clear_prog();
      put(0,  enc_i(6'h09, 5'd0, 5'd4, 16'hFFF8));
      put(1,  enc_r(5'd0, 5'd4, 5'd2, 5'd1,  6'h03));
      put(2,  enc_r(5'd0, 5'd4, 5'd2, 5'd28, 6'h02));
      put(3,  enc_r(5'd4, 5'd0, 5'd2, 5'd0,  6'h2A));
      put(4,  enc_r(5'd4, 5'd0, 5'd2, 5'd0,  6'h2B));
      put(5,  enc_i(6'h0C, 5'd4, 5'd2, 16'hFF0F));
      put(6,  enc_r(5'd4, 5'd0, 5'd2, 5'd0,  6'h27));
      put(7,  enc_r(5'd0, 5'd4, 5'd2, 5'd0,  6'h23));
      put(8,  enc_r(5'd0, 5'd4, 5'd2, 5'd4,  6'h00));
      put(9,  enc_i(6'h0E, 5'd4, 5'd2, 16'h00FF));
      put(10, enc_i(6'h0A, 5'd4, 5'd2, 16'hFFF9));
      put(11, JR0);
      put(12, NOP);
      exp_v0 = '{32'h0, 32'hFFFFFFFC, 32'h0000000F, 32'h1, 32'h0, 32'h0000FF08,
                 32'h00000007, 32'h8, 32'hFFFFFF80, 32'hFFFFFF07, 32'h1};
      do_reset();
      for (int i = 0; i < 11; i++) begin
        step();
        check($sformatf("alu_%0d", i), register_v0, exp_v0[i]);
      end
      run_halt(20, edges, writes);
      check("p6_edges", edges, 32'd2);
    end

    // JAL links PC+8 into $31
    clear_prog();
    put(0, {6'h03, 26'h3F00004});
    put(1, enc_i(6'h09, 5'd0, 5'd2, 16'h0007));
    put(2, enc_i(6'h09, 5'd0, 5'd2, 16'h0009));
    put(4, enc_r(5'd31, 5'd0, 5'd2, 5'd0, 6'h21));
    put(5, JR0);
    put(6, NOP);
    do_reset();
    step();
    step();
    check("jal_target", bus.instr_address, 32'hBFC00010);
    check("jal_slot_v0", register_v0, 32'd7);
    run_halt(20, edges, writes);
    check("jal_v0", register_v0, 32'hBFC00008);

    // Unsupported opcode 0x3F
    clear_prog();
    put(0, enc_i(6'h09, 5'd0, 5'd2, 16'h0003));
    put(1, 32'hFC000000);
    put(2, enc_i(6'h09, 5'd2, 5'd2, 16'h0001));
    put(3, JR0);
    put(4, NOP);
    do_reset();
    run_halt(20, edges, writes);
`ifdef MIPS_CPU_UNKNOWN_HALT_EN
    check("unk_edges", edges, 32'd2);
    check("unk_v0", register_v0, 32'd3);
    check("unk_pc", bus.instr_address, 32'hBFC00004);
`else
    check("unk_edges", edges, 32'd5);
    check("unk_v0", register_v0, 32'd4);
    check("unk_pc", bus.instr_address, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
